// File: rtl/enemy_formation_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | enemy_formation_renderer                                                   |
// | Alien formation state (alive map, position, march FSM) and per-pixel      |
// | sprite ROM addressing / enemy-layer colour output.                        |
// | Optional build macro: SPEEDUP_EN (step period shrinks as aliens die).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module enemy_formation_renderer #(
  parameter int SPR_W        = 39,
  parameter int SPR_H        = 39,
  parameter int COLS         = 8,
  parameter int ROWS         = 3,
  parameter int GAP          = 16,
  parameter int START_X      = 8,
  parameter int START_Y      = 40,
  parameter int X_MAX        = 640,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 20,
  parameter int Y_LIMIT      = 400,
  parameter int MOVE_DIV     = 30,
`ifdef SPEEDUP_EN
  parameter int MOVE_DIV_MIN = 4,
`endif
  parameter logic [11:0] TRANSP = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 pixel_valid,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  output logic [11:0]          mem_addr,
  output logic [1:0]           mem_type,
  input  logic [11:0]          mem_data,
  output logic [11:0]          rgb_out,
  output logic                 rgb_valid,
  input  logic                 kill_valid,
  input  logic [4:0]           kill_idx,
  output logic                 kill_ack,
  output logic                 kill_hit,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic                 all_dead,
  output logic                 reached_bottom
);

  localparam int PITCH = SPR_W + GAP;
  localparam int FW    = COLS * SPR_W + (COLS - 1) * GAP;
  localparam int FH    = ROWS * SPR_H + (ROWS - 1) * GAP;
  localparam int N     = ROWS * COLS;

  typedef enum logic [2:0] {MARCH_R, MARCH_L, DROP_L, DROP_R, HALT} state_t;

  state_t         state_q, state_d;
  logic [9:0]     fx_q, fx_d, fy_q, fy_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [N-1:0]   alive_q, alive_d;
  logic           bottom_q, bottom_d;
  logic           kill_ack_q, kill_ack_d, kill_hit_q, kill_hit_d;
  logic [11:0]    mem_addr_q, mem_addr_d;
  logic [1:0]     mem_type_q, mem_type_d;
  logic           hit1_q, hit1_d, hit2_q, hit2_d;
  logic [11:0]    rgb_q, rgb_d;
  logic           rgb_valid_q, rgb_valid_d;

  logic signed [11:0] dx, dy;
  logic        in_x, in_y, cell_alive, hit, step;
  logic [4:0]  col, row;
  logic [11:0] ox, oy;
  logic [15:0] period;

  assign dx = $signed({2'b00, pixel_x}) - $signed({2'b00, fx_q});
  assign dy = $signed({2'b00, pixel_y}) - $signed({2'b00, fy_q});

  // Cell decode by comparing against each column/row window, no division.
  always_comb begin
    in_x = 1'b0; col = '0; ox = '0;
    in_y = 1'b0; row = '0; oy = '0;
    cell_alive = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (dx >= c * PITCH && dx < c * PITCH + SPR_W) begin
        in_x = 1'b1; col = 5'(c); ox = 12'(dx - c * PITCH);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (dy >= r * PITCH && dy < r * PITCH + SPR_H) begin
        in_y = 1'b1; row = 5'(r); oy = 12'(dy - r * PITCH);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k == int'(row) * COLS + int'(col)) cell_alive = alive_q[k];
    end
    hit = pixel_valid & in_x & in_y & cell_alive;
  end

  always_comb begin
    mem_addr_d  = hit ? 12'(oy * SPR_W + ox) : mem_addr_q;
    mem_type_d  = mem_type_q;
    if (hit) mem_type_d = (row == 5'd0) ? 2'd0 : (row == 5'd1) ? 2'd1 : 2'd2;
    hit1_d      = hit;
    hit2_d      = hit1_q;
    rgb_valid_d = hit2_q & (mem_data != TRANSP);
    rgb_d       = rgb_valid_d ? mem_data : 12'h000;
  end

  always_comb begin
    alive_d    = alive_q;
    kill_ack_d = kill_valid;
    kill_hit_d = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (kill_valid && kill_idx == 5'(k) && alive_q[k]) begin
        kill_hit_d = 1'b1;
        alive_d[k] = 1'b0;
      end
    end
  end

`ifdef SPEEDUP_EN
  logic [5:0] pop;
  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) pop = pop + {5'b0, alive_q[k]};
    period = 16'(MOVE_DIV_MIN) + {10'b0, pop};
  end
`else
  assign period = 16'(MOVE_DIV);
`endif

  always_comb begin
    state_d  = state_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    bottom_d = bottom_q;
    cnt_d    = cnt_q;
    step     = frame_tick && (cnt_q >= period - 16'd1);
    if (frame_tick) cnt_d = step ? 16'd0 : cnt_q + 16'd1;
    if (step && state_q != HALT) begin
      if (all_dead) begin
        state_d = HALT;
      end else begin
        case (state_q)
          MARCH_R: if (int'(fx_q) + FW + STEP_X > X_MAX) state_d = DROP_L;
                   else fx_d = fx_q + 10'(STEP_X);
          MARCH_L: if (int'(fx_q) < STEP_X) state_d = DROP_R;
                   else fx_d = fx_q - 10'(STEP_X);
          DROP_L, DROP_R: begin
            fy_d    = fy_q + 10'(STEP_Y);
            state_d = (state_q == DROP_L) ? MARCH_L : MARCH_R;
            if (int'(fy_q) + STEP_Y + FH >= Y_LIMIT) begin
              bottom_d = 1'b1;
              state_d  = HALT;
            end
          end
          default: state_d = HALT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MARCH_R;
      fx_q        <= 10'(START_X);
      fy_q        <= 10'(START_Y);
      cnt_q       <= '0;
      alive_q     <= '1;
      bottom_q    <= 1'b0;
      kill_ack_q  <= 1'b0;
      kill_hit_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_type_q  <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      cnt_q       <= cnt_d;
      alive_q     <= alive_d;
      bottom_q    <= bottom_d;
      kill_ack_q  <= kill_ack_d;
      kill_hit_q  <= kill_hit_d;
      mem_addr_q  <= mem_addr_d;
      mem_type_q  <= mem_type_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_type       = mem_type_q;
  assign rgb_out        = rgb_q;
  assign rgb_valid      = rgb_valid_q;
  assign kill_ack       = kill_ack_q;
  assign kill_hit       = kill_hit_q;
  assign alive_mask     = alive_q;
  assign all_dead       = (alive_q == '0);
  assign reached_bottom = bottom_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_formation_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_enemy_formation_renderer                                                |
// | Randomized bench with a behavioural formation/render model and ROM model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_enemy_formation_renderer;

  localparam int SPR_W = 39, SPR_H = 39, COLS = 8, ROWS = 3, GAP = 16;
  localparam int PITCH = SPR_W + GAP;
  localparam int FW = COLS * SPR_W + (COLS - 1) * GAP;
  localparam int FH = ROWS * SPR_H + (ROWS - 1) * GAP;
  localparam int N  = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, pixel_valid = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [11:0] mem_addr, rgb_out;
  logic [1:0]  mem_type;
  logic [11:0] mem_data = '0;
  logic        rgb_valid, kill_valid = 1'b0, kill_ack, kill_hit;
  logic [4:0]  kill_idx = '0;
  logic [N-1:0] alive_mask;
  logic        all_dead, reached_bottom;

  int n_pass = 0, n_checks = 0;

  // behavioural model state
  int  m_fx, m_fy, m_ticks;
  logic [N-1:0] m_alive;
  bit  m_right, m_drop, m_halt, m_bottom;

  typedef struct { logic [11:0] rgb; logic vld; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  enemy_formation_renderer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .mem_addr(mem_addr), .mem_type(mem_type),
    .mem_data(mem_data), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .kill_valid(kill_valid), .kill_idx(kill_idx), .kill_ack(kill_ack), .kill_hit(kill_hit),
    .alive_mask(alive_mask), .all_dead(all_dead), .reached_bottom(reached_bottom)
  );

  function automatic logic [11:0] rom_word(input logic [11:0] a, input logic [1:0] t);
    if (a[2:0] == 3'd5) return 12'h000;
    return (a ^ {t, 10'h2A5}) | 12'h001;
  endfunction

  always @(posedge clk) mem_data <= rom_word(mem_addr, mem_type);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_fx = 8; m_fy = 40; m_ticks = 0; m_alive = '1;
    m_right = 1; m_drop = 0; m_halt = 0; m_bottom = 0;
  endtask

  task automatic model_render(input int x, input int y, input bit v,
                              output bit hit, output int addr, output int typ);
    int dx, dy, col, row, ox, oy;
    dx = x - m_fx; dy = y - m_fy; hit = 0; addr = 0; typ = 0;
    if (v && dx >= 0 && dy >= 0) begin
      col = dx / PITCH; ox = dx % PITCH; row = dy / PITCH; oy = dy % PITCH;
      if (col < COLS && row < ROWS && ox < SPR_W && oy < SPR_H && m_alive[row*COLS+col]) begin
        hit = 1; addr = oy * SPR_W + ox; typ = (row >= 2) ? 2 : row;
      end
    end
  endtask

  function automatic int model_period();
`ifdef SPEEDUP_EN
    return 4 + $countones(m_alive);
`else
    return 30;
`endif
  endfunction

  task automatic model_step();
    if (m_halt) return;
    if (m_alive == 0) begin m_halt = 1; return; end
    if (m_drop) begin
      m_fy += 20; m_drop = 0; m_right = !m_right;
      if (m_fy + FH >= 400) begin m_bottom = 1; m_halt = 1; end
    end else if (m_right) begin
      if (m_fx + FW + 4 > 640) m_drop = 1; else m_fx += 4;
    end else begin
      if (m_fx < 4) m_drop = 1; else m_fx -= 4;
    end
  endtask

  task automatic model_tick();
    m_ticks++;
    if (m_ticks >= model_period()) begin m_ticks = 0; model_step(); end
  endtask

  task automatic check_pos(input string tag);
    chk({tag, "_fx"}, dut.fx_q, m_fx);
    chk({tag, "_fy"}, dut.fy_q, m_fy);
    chk({tag, "_bottom"}, reached_bottom, m_bottom);
  endtask

  task automatic check_reset_state();
    chk("rst_addr", mem_addr, 0);      chk("rst_type", mem_type, 0);
    chk("rst_rgb", rgb_out, 0);        chk("rst_rgbv", rgb_valid, 0);
    chk("rst_ack", kill_ack, 0);       chk("rst_hit", kill_hit, 0);
    chk("rst_mask", alive_mask, 24'hFFFFFF);
    chk("rst_dead", all_dead, 0);
    check_pos("rst");
  endtask

  task automatic held_pixel(input int x, input int y);
    bit h; int a, t; logic [11:0] w;
    @(negedge clk);
    pixel_valid = 1; pixel_x = 10'(x); pixel_y = 10'(y);
    model_render(x, y, 1, h, a, t);
    repeat (3) @(posedge clk);
    #1;
    w = h ? rom_word(12'(a), 2'(t)) : 12'h000;
    chk("px_rgbv", rgb_valid, (w != 0));
    chk("px_rgb", rgb_out, w);
    if (h) begin chk("px_addr", mem_addr, a); chk("px_type", mem_type, t); end
    @(negedge clk) pixel_valid = 0;
  endtask

  task automatic stream(input int n);
    bit h; int a, t, x, y; bit v; exp_t e;
    q.delete();
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (q.size() == 3) begin
        e = q.pop_front();
        chk("st_rgbv", rgb_valid, e.vld);
        chk("st_rgb", rgb_out, e.rgb);
      end
      x = m_fx + int'($urandom_range(0, FW + 10)) - 5; if (x < 0) x = 0; if (x > 1023) x = 1023;
      y = m_fy + int'($urandom_range(0, FH + 10)) - 5; if (y < 0) y = 0; if (y > 1023) y = 1023;
      v = (i < n) && ($urandom_range(0, 9) != 0);
      pixel_valid = v; pixel_x = 10'(x); pixel_y = 10'(y);
      model_render(x, y, v, h, a, t);
      e.rgb = h ? rom_word(12'(a), 2'(t)) : 12'h000;
      e.vld = (e.rgb != 0);
      q.push_back(e);
    end
    pixel_valid = 0;
  endtask

  task automatic kill_one(input int idx, input bit hold_next, input int idx2);
    bit eh;
    @(negedge clk);
    kill_valid = 1; kill_idx = 5'(idx);
    eh = (idx < N) && m_alive[idx];
    if (eh) m_alive[idx] = 0;
    @(posedge clk); #1;
    chk("kill_ack", kill_ack, 1); chk("kill_hit", kill_hit, eh); chk("kill_mask", alive_mask, m_alive);
    if (hold_next) begin
      kill_idx = 5'(idx2);
      eh = (idx2 < N) && m_alive[idx2];
      if (eh) m_alive[idx2] = 0;
      @(posedge clk); #1;
      chk("b2b_ack", kill_ack, 1); chk("b2b_hit", kill_hit, eh); chk("b2b_mask", alive_mask, m_alive);
    end
    @(negedge clk) kill_valid = 0;
    @(posedge clk); #1;
    chk("kill_ack_low", kill_ack, 0);
  endtask

  task automatic tick(input bit with_kill, input int idx);
    bit eh;
    @(negedge clk);
    frame_tick = 1;
    model_tick();
    eh = 0;
    if (with_kill) begin
      kill_valid = 1; kill_idx = 5'(idx);
      eh = (idx < N) && m_alive[idx];
      if (eh) m_alive[idx] = 0;
    end
    @(posedge clk); #1;
    frame_tick = 0; kill_valid = 0;
    if (with_kill) begin
      chk("tk_ack", kill_ack, 1); chk("tk_hit", kill_hit, eh); chk("tk_mask", alive_mask, m_alive);
      check_pos("tk");
    end else if (m_ticks == 0) begin
      check_pos("step");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    model_reset();
    #1 check_reset_state();
    @(negedge clk) rst = 0;
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rst = 0;

    held_pixel(9, 42);
    chk("dir_addr79", mem_addr, 79); chk("dir_type0", mem_type, 0);
    held_pixel(66, 96);
    chk("dir_addr42", mem_addr, 42); chk("dir_type1", mem_type, 1);
    held_pixel(47, 40);
    chk("gap_rgbv", rgb_valid, 0);
    stream(200);

    kill_one(9, 0, 0);
    chk("bit9", alive_mask[9], 0);
    held_pixel(66, 96);
    chk("dead_rgbv", rgb_valid, 0);
    kill_one(9, 0, 0);
    kill_one(30, 0, 0);
    for (int i = 0; i < 4; i++) kill_one($urandom_range(0, 31), 1, $urandom_range(0, 31));
    stream(200);

    for (int i = 0; i < 40 * model_period() + 3; i++) tick(0, 0);
    stream(200);
    guard = 0;
    while (m_ticks != model_period() - 1 && guard < 100) begin tick(0, 0); guard++; end
    tick(1, $urandom_range(0, N - 1));

    // kill in flight cut off by reset: no ack afterwards
    @(negedge clk);
    kill_valid = 1; kill_idx = 5'd3;
    #2 rst = 1;
    model_reset();
    #1 check_reset_state();
    @(negedge clk) begin rst = 0; kill_valid = 0; end
    @(posedge clk); #1 chk("abort_ack", kill_ack, 0);

    for (int k = 0; k < N; k++) kill_one(k, 0, 0);
    chk("all_dead", all_dead, 1);
    chk("all_dead_mask", alive_mask, 0);
    for (int i = 0; i < 100; i++) tick(0, 0);
    check_pos("dead_frozen");

    do_reset();
    guard = 0;
    while (!m_halt && guard < 40000) begin tick(0, 0); guard++; end
    chk("bottom_reached_in_budget", m_halt, 1);
    chk("bottom_flag", reached_bottom, 1);
    for (int i = 0; i < 100; i++) tick(0, 0);
    check_pos("halt_frozen");
    stream(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
